lane_tx_scheduler: RTL

Transmit-side scheduler for the two-lane distributer. It arbitrates between the ordered-set generator and the transport-layer data path. It drives the distributer's enable_t and d_sel so that ordered sets and 4-byte-aligned data blocks never interleave mid-block, and it bounds data starvation under continuous ordered-set traffic.

---
 rtl/lane_tx_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lane_tx_scheduler.sv
// Transmit-side scheduler arbitrating ordered-set bursts against 4-byte data blocks
// for the two-lane distributer. Optional block counters behind LANE_SCHED_STATS_EN.
module lane_tx_scheduler #(
    parameter int OS_LEN     = 16,
    parameter int DATA_BLK   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_en,
    input  logic        os_req,
    input  logic [3:0]  os_type,
    output logic        os_gnt,
    output logic        os_busy,
    input  logic        data_req,
    output logic        data_gnt,
    output logic        enable_t,
    output logic [3:0]  d_sel,
    output logic        abort,
    output logic        illegal_os,
    output logic [15:0] os_blk_cnt,
    output logic [15:0] data_blk_cnt
);

    localparam int BLK_MAX = (OS_LEN > DATA_BLK) ? OS_LEN : DATA_BLK;
    localparam int CW      = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;
    localparam int SW      = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] OS_LAST    = CW'(OS_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_BLK - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [3:0] DSEL_DATA = 4'h8;
    localparam logic [3:0] DSEL_IDLE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OS,
        S_DATA
    } state_t;

    state_t        state;
    logic [CW-1:0] bcnt;
    logic [SW-1:0] starve_cnt;

    logic          os_last;
    logic          data_last;
    logic          arb;
    logic          mid_drop;
    logic          os_bad;
    logic          os_win;
    logic [SW-1:0] starve_eff;

    always_comb begin
        os_last   = (state == S_OS)   && (bcnt == OS_LAST);
        data_last = (state == S_DATA) && (bcnt == DATA_LAST);
        mid_drop  = (state != S_IDLE) && !link_en;
        arb       = ((state == S_IDLE) && link_en) || os_last || data_last;

        // Starvation count as it stands after the burst now finishing, so the
        // decision taken at that same edge already sees the updated value.
        starve_eff = starve_cnt;
        if (os_last) begin
            if (!data_req)
                starve_eff = '0;
            else if (starve_cnt != STARVE_LIM)
                starve_eff = starve_cnt + SW'(1);
        end

        os_bad = os_req && os_type[3];
        os_win = os_req && !os_type[3] && ((starve_eff < STARVE_LIM) || !data_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bcnt       <= '0;
            starve_cnt <= '0;
            os_gnt     <= 1'b0;
            os_busy    <= 1'b0;
            data_gnt   <= 1'b0;
            enable_t   <= 1'b0;
            d_sel      <= DSEL_IDLE;
            abort      <= 1'b0;
            illegal_os <= 1'b0;
        end else begin
            os_gnt     <= 1'b0;
            abort      <= 1'b0;
            illegal_os <= 1'b0;

            if (mid_drop) begin
                state      <= S_IDLE;
                bcnt       <= '0;
                starve_cnt <= '0;
                os_busy    <= 1'b0;
                data_gnt   <= 1'b0;
                enable_t   <= 1'b0;
                d_sel      <= DSEL_IDLE;
                abort      <= 1'b1;
            end else if (arb) begin
                bcnt       <= '0;
                enable_t   <= link_en;
                illegal_os <= os_bad;
                if (os_win) begin
                    state      <= S_OS;
                    starve_cnt <= starve_eff;
                    os_gnt     <= 1'b1;
                    os_busy    <= 1'b1;
                    data_gnt   <= 1'b0;
                    d_sel      <= os_type;
                end else if (data_req) begin
                    state      <= S_DATA;
                    starve_cnt <= '0;
                    os_busy    <= 1'b0;
                    data_gnt   <= 1'b1;
                    d_sel      <= DSEL_DATA;
                end else begin
                    state      <= S_IDLE;
                    starve_cnt <= starve_eff;
                    os_busy    <= 1'b0;
                    data_gnt   <= 1'b0;
                    d_sel      <= DSEL_IDLE;
                end
            end else if (state == S_IDLE) begin
                // link disabled while idle: hold the lane quiet, nothing to abort
                bcnt     <= '0;
                enable_t <= 1'b0;
                os_busy  <= 1'b0;
                data_gnt <= 1'b0;
                d_sel    <= DSEL_IDLE;
            end else begin
                bcnt <= bcnt + CW'(1);
            end
        end
    end

`ifdef LANE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            os_blk_cnt   <= '0;
            data_blk_cnt <= '0;
        end else if (!mid_drop) begin
            if (os_last && (os_blk_cnt != 16'hFFFF))
                os_blk_cnt <= os_blk_cnt + 16'd1;
            if (data_last && (data_blk_cnt != 16'hFFFF))
                data_blk_cnt <= data_blk_cnt + 16'd1;
        end
    end
`else
    assign os_blk_cnt   = 16'h0;
    assign data_blk_cnt = 16'h0;
`endif

endmodule
